// File: rtl/gpio_pad_sequencer.sv
// GPIO bank controller: break-before-make direction turnaround on the pad controls,
// plus a synchronised, glitch-filtered view of the pad inputs for core logic.
//
//   state | meaning
//   IDLE  | directions applied; configs accepted, pad_o updated on each accept
//   GAP   | changing pads held with oe=ie=0 until the new direction is enabled
module gpio_pad_sequencer #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_dir,
    input  logic [WIDTH-1:0] cfg_out,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_ie,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] dir,
    output logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] in_change,
    output logic             busy
);

    localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT  = CW'(TURN_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] chg;

    assign chg = cfg_dir ^ dir;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dir       <= '0;
            pending   <= '0;
            cnt       <= '0;
            pad_oe    <= '0;
            pad_ie    <= '1;
            pad_o     <= '0;
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        pad_o <= cfg_out;
                        if (chg != '0) begin
                            // only the changing pads are cut; the rest keep driving/receiving
                            pad_oe    <= pad_oe & ~chg;
                            pad_ie    <= pad_ie & ~chg;
                            pending   <= cfg_dir;
                            cnt       <= CNT_INIT;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        dir       <= pending;
                        pad_oe    <= pending;
                        pad_ie    <= ~pending;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [FW-1:0]    fcnt [WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= '0;
            s2        <= '0;
            in_data   <= '0;
            in_change <= '0;
            for (int k = 0; k < WIDTH; k++) fcnt[k] <= '0;
        end else begin
            s1        <= pad_i;
            s2        <= s1;
            in_change <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                if (s2[k] != in_data[k]) begin
                    if (fcnt[k] == FCNT_LAST) begin
                        in_data[k]   <= s2[k];
                        in_change[k] <= 1'b1;
                        fcnt[k]      <= '0;
                    end else begin
                        fcnt[k] <= fcnt[k] + FW'(1);
                    end
                end else begin
                    fcnt[k] <= '0;
                end
            end
        end
    end

endmodule
